// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the decode-side pipeline control logic.
//   REG_W      - architectural register index width
//   REG_ZERO   - index of the hard-wired zero register (never a hazard source)
//   hz_state_t - hazard controller state
package cpu_pkg;

   localparam int                REG_W    = 5;
   localparam logic [REG_W-1:0]  REG_ZERO = 5'd0;

   typedef enum logic {
      HZ_IDLE,
      HZ_MUL_BUSY
   } hz_state_t;

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// sat_counter: free-running up counter with enable that sticks at all-ones.
//   clk   - rising-edge clock
//   rst   - asynchronous active-low clear
//   en    - count this edge
//   count - current value
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (en && (cnt_q != {W{1'b1}}))
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign count = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush controller for the IF, IF/ID and ID/EX stages.
//   Inputs : ID source regs + use flags, EX destination / load flag,
//            EX multiply start, EX-resolved taken branch (PC_src).
//   Outputs: PC_hazard   - hold PC
//            data_hazard - hold IF/ID, bubble ID/EX
//            flush_if_id - squash IF/ID
//            flush_id_ex - squash ID/EX
//            mul_busy    - multiply occupying EX (registered)
//            stall_count - saturating count of data_hazard cycles
// Hazard outputs are Mealy: they react to the current inputs in the same
// cycle so the front end can be held with zero detection latency.
module hazard_unit
   import cpu_pkg::*;
#(
   parameter int MUL_LAT = 4,   // total EX cycles of a multiply, >= 2
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_mul_start,
   input  logic             PC_src,
   output logic             PC_hazard,
   output logic             data_hazard,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             mul_busy,
   output logic [CNT_W-1:0] stall_count
);

   localparam int MC_W = $clog2(MUL_LAT) + 1;

   hz_state_t       state_d, state_q;
   logic [MC_W-1:0] mul_cnt_d, mul_cnt_q;

   logic load_use;
   logic ph_c, dh_c, fif_c, fie_c;

   // Load in EX whose result is needed by the instruction in ID; r0 is
   // hard-wired so it can never carry a dependency.
   assign load_use = id_valid & ex_mem_read & (ex_rd != REG_ZERO) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                      (id_uses_rs2 & (id_rs2 == ex_rd)));

   always_comb begin
      state_d   = state_q;
      mul_cnt_d = mul_cnt_q;
      ph_c      = 1'b0;
      dh_c      = 1'b0;
      fif_c     = 1'b0;
      fie_c     = 1'b0;
      case (state_q)
         HZ_IDLE: begin
            if (PC_src) begin
               // ID holds a wrong-path instruction, so any load-use match
               // against it is meaningless; squash both younger slots.
               fif_c = 1'b1;
               fie_c = 1'b1;
            end else begin
               if (load_use) begin
                  ph_c  = 1'b1;
                  dh_c  = 1'b1;
                  fie_c = 1'b1;
               end
               if (ex_mul_start) begin
                  state_d   = HZ_MUL_BUSY;
                  mul_cnt_d = MC_W'(MUL_LAT - 1);
               end
            end
         end
         HZ_MUL_BUSY: begin
            // EX keeps the multiply, so no bubble is pushed into ID/EX and
            // branch / new multiply requests cannot originate from EX.
            ph_c      = 1'b1;
            dh_c      = 1'b1;
            mul_cnt_d = mul_cnt_q - MC_W'(1);
            if (mul_cnt_q <= MC_W'(1)) begin
               state_d   = HZ_IDLE;
               mul_cnt_d = '0;
            end
         end
         default: begin
            state_d   = HZ_IDLE;
            mul_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= HZ_IDLE;
         mul_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         mul_cnt_q <= mul_cnt_d;
      end
   end

   // Gate with rst so the combinational outputs stay quiet during reset
   // regardless of what the pipeline is presenting.
   assign PC_hazard   = rst & ph_c;
   assign data_hazard = rst & dh_c;
   assign flush_if_id = rst & fif_c;
   assign flush_id_ex = rst & fie_c;
   assign mul_busy    = rst & (state_q == HZ_MUL_BUSY);

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (data_hazard),
      .count (stall_count)
   );

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scoreboard bench for hazard_unit. A behavioural model
// predicts each cycle's outputs when stimulus is applied; the prediction is
// queued and popped/compared once the DUT outputs have settled. A second
// instance with CNT_W=4 shares the stimulus to exercise counter saturation.
module tb_hazard_unit;

   localparam int MUL_LAT = 4;

   logic       clk, rst;
   logic       id_valid, id_uses_rs1, id_uses_rs2;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       ex_mem_read, ex_mul_start, PC_src;

   logic        PC_hazard, data_hazard, flush_if_id, flush_id_ex, mul_busy;
   logic [15:0] stall_count;
   logic        s_ph, s_dh, s_fif, s_fie, s_mb;
   logic [3:0]  s_cnt;

   hazard_unit #(.MUL_LAT(MUL_LAT), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_mul_start(ex_mul_start), .PC_src(PC_src),
      .PC_hazard(PC_hazard), .data_hazard(data_hazard), .flush_if_id(flush_if_id),
      .flush_id_ex(flush_id_ex), .mul_busy(mul_busy), .stall_count(stall_count)
   );

   hazard_unit #(.MUL_LAT(MUL_LAT), .CNT_W(4)) u_dut_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_mul_start(ex_mul_start), .PC_src(PC_src),
      .PC_hazard(s_ph), .data_hazard(s_dh), .flush_if_id(s_fif),
      .flush_id_ex(s_fie), .mul_busy(s_mb), .stall_count(s_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        ph, dh, fif, fie, mb;
      logic [15:0] cnt;
      logic [3:0]  cnt4;
   } exp_t;

   exp_t sb_q[$];

   int n_cmp = 0;
   int n_err = 0;

   // model state
   logic        m_busy = 1'b0;
   int          m_left = 0;
   logic [15:0] m_cnt  = '0;
   logic [3:0]  m_cnt4 = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: apply inputs at the falling edge, predict, compare
   // just after, then advance the model at the rising edge.
   task automatic step(input logic r, input logic v,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic mr, input logic ms, input logic ps);
      exp_t e;
      exp_t o;
      logic lu;
      @(negedge clk);
      rst = r; id_valid = v; id_rs1 = rs1; id_rs2 = rs2;
      id_uses_rs1 = u1; id_uses_rs2 = u2; ex_rd = rd;
      ex_mem_read = mr; ex_mul_start = ms; PC_src = ps;
      if (!r) begin
         m_busy = 1'b0; m_left = 0; m_cnt = '0; m_cnt4 = '0;
      end
      lu = v && mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      e = '0;
      e.cnt  = m_cnt;
      e.cnt4 = m_cnt4;
      if (r) begin
         if (m_busy)  begin e.ph = 1'b1; e.dh = 1'b1; e.mb = 1'b1; end
         else if (ps) begin e.fif = 1'b1; e.fie = 1'b1; end
         else if (lu) begin e.ph = 1'b1; e.dh = 1'b1; e.fie = 1'b1; end
      end
      sb_q.push_back(e);
      #1;
      o = sb_q.pop_front();
      chk("PC_hazard",   PC_hazard,   o.ph);
      chk("data_hazard", data_hazard, o.dh);
      chk("flush_if_id", flush_if_id, o.fif);
      chk("flush_id_ex", flush_id_ex, o.fie);
      chk("mul_busy",    mul_busy,    o.mb);
      chk("stall_count", stall_count, o.cnt);
      chk("sat_PC_hazard",   s_ph,  o.ph);
      chk("sat_stall_count", s_cnt, o.cnt4);
      @(posedge clk);
      if (r) begin
         if (o.dh) begin
            if (m_cnt  != 16'hFFFF) m_cnt  = m_cnt + 16'd1;
            if (m_cnt4 != 4'hF)     m_cnt4 = m_cnt4 + 4'd1;
         end
         if (m_busy) begin
            m_left--;
            if (m_left == 0) m_busy = 1'b0;
         end else if (!ps && ms) begin
            m_busy = 1'b1;
            m_left = MUL_LAT - 1;
         end
      end
   endtask

   task automatic idle();
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0;
      id_uses_rs2 = 0; ex_rd = 0; ex_mem_read = 0; ex_mul_start = 0; PC_src = 0;

      // reset with hostile inputs: everything must stay low
      step(0, 1, 5, 5, 1, 1, 5, 1, 1, 1);
      step(0, 1, 5, 5, 1, 1, 5, 1, 1, 1);
      idle();

      // load-use on rs1, then load has moved on
      step(1, 1, 5, 0, 1, 0, 5, 1, 0, 0);
      step(1, 1, 5, 0, 1, 0, 5, 0, 0, 0);
      // r0 never hazards
      step(1, 1, 0, 0, 1, 1, 0, 1, 0, 0);
      // match on rs2 but not read / ID empty
      step(1, 1, 1, 7, 1, 0, 7, 1, 0, 0);
      step(0 == 1 ? 0 : 1, 0, 7, 7, 1, 1, 7, 1, 0, 0);
      // load-use on rs2
      step(1, 1, 1, 9, 0, 1, 9, 1, 0, 0);

      // multiply: three busy cycles after the start cycle
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      repeat (4) idle();
      #1 chk("stall_after_mul", stall_count, 16'd5);

      // branch beats a simultaneous load-use on rs2
      step(1, 1, 2, 6, 1, 1, 6, 1, 0, 1);
      // branch beats multiply start; no busy afterwards
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle();

      // branch and multiply start ignored while busy
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 1, 3, 3, 1, 1, 3, 1, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle();

      // reset during the second busy cycle
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      idle();
      #1 chk("post_reset_busy", mul_busy, 1'b0);

      // back-to-back multiplies saturate the narrow counter
      repeat (30) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      repeat (4) idle();
      #1 chk("sat_hold", s_cnt, 4'hF);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         step(1, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
